yseq_ctrl: RTL and testbench

YSEQ_CTRL -- requirements
Module: yseq_ctrl

---
 rtl/yseq_if.sv | 21 ++
 rtl/yseq_ctrl.sv | 75 +++++++
 tb/tb_yseq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/yseq_if.sv
// yseq_if: datapath <-> sequencer control bundle
// master (datapath side): drives start, ins, zero; observes all control/status outputs
// slave (yseq_ctrl side): receives start, ins, zero; drives RegWrite, ALUSrc, MemRead,
//   MemWrite, Mem2Reg, op, pc_write, pc_sel, ins_count, busy, done, err
interface yseq_if;
  logic        start;
  logic [31:0] ins;
  logic        zero;
  logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic [2:0]  op;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic [15:0] ins_count;
  logic        busy, done, err;
  modport master(output start, ins, zero,
                 input RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, pc_write, pc_sel,
                 ins_count, busy, done, err);
  modport slave(input start, ins, zero,
                output RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, pc_write, pc_sel,
                ins_count, busy, done, err);
endinterface

// File: rtl/yseq_ctrl.sv
// yseq_ctrl: multi-cycle instruction sequencer that halts after MAX_INS retirements
// clk, rst_n (async active-low); bus: yseq_if.slave carrying start/ins/zero in and
// datapath controls, PC strobe/select, retired count and busy/done/err status out
module yseq_ctrl #(parameter int MAX_INS = 43) (
  input logic   clk,
  input logic   rst_n,
  yseq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [15:0] MAXC = 16'(MAX_INS);
  state_t      st, nx;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        f7, err_r;
  logic [15:0] cnt, cnt_n;
  logic        r_t, i_t, ld, sd, bq, jl, unk, ex, last;
  always_comb begin
    r_t = opc == 7'h33;
    i_t = opc == 7'h13;
    ld = opc == 7'h03;
    sd = opc == 7'h23;
    bq = opc == 7'h63;
    jl = opc == 7'h6F;
    unk = !(r_t || i_t || ld || sd || bq || jl);
    ex = st == EXEC || st == MEM || st == WB;
    // WB is only reached by sequences that end there, so it is always a retiring state
    last = (st == DECODE && unk) || (st == EXEC && bq) || (st == MEM && sd) || st == WB;
    cnt_n = cnt == 16'hFFFF ? cnt : cnt + 16'd1;
    nx = st;
    case (st)
      IDLE:    nx = bus.start ? FETCH : IDLE;
      FETCH:   nx = DECODE;
      DECODE:  nx = EXEC;
      EXEC:    nx = (ld || sd) ? MEM : WB;
      MEM:     nx = WB;
      default: nx = st;
    endcase
    if (last) nx = cnt_n >= MAXC ? HALT : FETCH;
    bus.pc_write = last;
    bus.pc_sel = !last ? 2'b00 : (bq && bus.zero) ? 2'b01 : jl ? 2'b10 : 2'b00;
    bus.ALUSrc = ex && (i_t || ld || sd || jl);
    bus.op = !ex ? 3'b010 :
             (r_t && f3 == 3'b000 && f7) ? 3'b110 :
             (r_t && f3 == 3'b111) ? 3'b000 :
             (r_t && f3 == 3'b110) ? 3'b001 :
             bq ? 3'b110 : 3'b010;
    bus.MemRead = st == MEM && ld;
    bus.MemWrite = st == MEM && sd;
    bus.Mem2Reg = st == WB && ld;
    bus.RegWrite = st == WB && (r_t || i_t || ld || jl);
    bus.busy = st == FETCH || st == DECODE || ex;
    bus.done = st == HALT;
    // err shows already in the DECODE cycle of an unknown opcode, then stays via err_r
    bus.err = err_r || (st == DECODE && unk);
    bus.ins_count = cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      opc <= '0;
      f3 <= '0;
      f7 <= 1'b0;
      cnt <= '0;
      err_r <= 1'b0;
    end else begin
      st <= nx;
      if (st == FETCH) begin
        opc <= bus.ins[6:0];
        f3 <= bus.ins[14:12];
        f7 <= bus.ins[30];
      end
      if (last) cnt <= cnt_n;
      if (st == DECODE && unk) err_r <= 1'b1;
    end
endmodule

// File: tb/tb_yseq_ctrl.sv
// tb_yseq_ctrl: randomized sequencer check against an instruction-level model plus literal pins
module tb_yseq_ctrl;
  logic clk = 0, rst_n = 0, rst2_n = 0;
  always #5 clk = ~clk;
  yseq_if a();
  yseq_if b();
  yseq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(a));
  yseq_ctrl #(.MAX_INS(2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(b));
  localparam int MAXI = 43;
  typedef struct packed {
    logic rw, as, mr, mw, m2r;
    logic [2:0] op;
    logic pw;
    logic [1:0] ps;
    logic [15:0] cnt;
    logic busy, done, err;
  } o_t;
  int n_chk = 0, n_fail = 0, c = 0, seq_len = 0;
  bit e = 0, halted = 0, chk = 0, ab;
  o_t exp, g;
  o_t snap[7];
  function automatic o_t cur();
    return {a.RegWrite, a.ALUSrc, a.MemRead, a.MemWrite, a.Mem2Reg, a.op, a.pc_write,
            a.pc_sel, a.ins_count, a.busy, a.done, a.err};
  endfunction
  // phase: 0 idle, 1 fetch, 2 decode, 3 exec, 4 mem, 5 wb, 6 halt
  function automatic o_t model(int ph, logic [31:0] i, logic z, int cn, bit er);
    o_t o;
    logic [6:0] p;
    bit R, I, L, S, B, J, U, x;
    int lst;
    p = i[6:0];
    R = p == 7'h33; I = p == 7'h13; L = p == 7'h03; S = p == 7'h23; B = p == 7'h63; J = p == 7'h6F;
    U = !(R || I || L || S || B || J);
    lst = U ? 2 : B ? 3 : S ? 4 : 5;
    x = ph >= 3 && ph <= 5;
    o = '0;
    o.busy = ph >= 1 && ph <= 5;
    o.done = ph == 6;
    o.cnt = 16'(cn);
    o.err = er || (ph == 2 && U);
    o.pw = ph == lst;
    o.ps = !o.pw ? 2'd0 : (B && z) ? 2'd1 : J ? 2'd2 : 2'd0;
    o.as = x && (I || L || S || J);
    o.op = !x ? 3'b010 : (R && i[14:12] == 3'd0 && i[30]) ? 3'b110 : (R && i[14:12] == 3'd7) ? 3'b000 :
           (R && i[14:12] == 3'd6) ? 3'b001 : B ? 3'b110 : 3'b010;
    o.mr = ph == 4 && L;
    o.mw = ph == 4 && S;
    o.m2r = ph == 5 && L;
    o.rw = ph == 5 && (R || I || L || J);
    return o;
  endfunction
  always @(negedge clk) begin
    #2;
    if (chk) begin
      g = cur();
      n_chk++;
      if (g !== exp) begin
        n_fail++;
        $display("FAIL cycle t=%0t got=%h want=%h", $time, g, exp);
      end
    end
  end
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; a.start = 1'($urandom_range(0, 1)); c = 0; e = 0; halted = 0;
    exp = model(0, 0, 0, 0, 0); chk = 1;
    @(negedge clk);
    a.start = 0;
    #3 rst_n = 1;
  endtask
  task automatic idle_cyc(input bit st);
    @(negedge clk);
    a.start = st; a.ins = $urandom; a.zero = 1'($urandom_range(0, 1));
    exp = model(0, 0, 0, c, e); chk = 1;
    #3;
  endtask
  task automatic halt_cyc();
    @(negedge clk);
    a.start = 1'($urandom_range(0, 1)); a.zero = 1'($urandom_range(0, 1));
    exp = model(6, 0, 0, c, e);
    #3;
  endtask
  task automatic run_ins(input logic [31:0] i, input int zm, input int rph, output bit abt);
    logic [6:0] p;
    bit S, W, U;
    int seq[$];
    p = i[6:0];
    S = p == 7'h23;
    W = p == 7'h33 || p == 7'h13 || p == 7'h03 || p == 7'h6F;
    U = !(W || S || p == 7'h63);
    seq = {1, 2};
    if (!U) seq.push_back(3);
    if (p == 7'h03 || S) seq.push_back(4);
    if (W) seq.push_back(5);
    seq_len = seq.size();
    abt = 0;
    foreach (seq[k]) begin
      if (seq[k] == rph) begin
        do_reset();
        abt = 1;
        return;
      end
      @(negedge clk);
      a.start = 1'($urandom_range(0, 1));
      a.zero = zm == 2 ? 1'($urandom_range(0, 1)) : 1'(zm);
      a.ins = seq[k] == 1 ? i : $urandom;
      exp = model(seq[k], i, a.zero, c, e);
      #3 snap[seq[k]] = cur();
    end
    if (U) e = 1;
    if (c < 65535) c++;
    if (c >= MAXI) halted = 1;
  endtask
  function automatic logic [31:0] rnd_ins();
    logic [31:0] w;
    logic [6:0] t[7];
    int k;
    t = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h00};
    w = $urandom;
    k = $urandom_range(0, 7);
    if (k < 7) w[6:0] = t[k];
    return w;
  endfunction
  initial begin
    a.start = 0; a.ins = 0; a.zero = 0; b.start = 0; b.ins = 0; b.zero = 0;
    do_reset();
    rst2_n = 1;
    lit("rst_cnt", a.ins_count, 0);
    lit("rst_busy", a.busy, 0);
    lit("rst_pw", a.pc_write, 0);
    lit("rst_op", a.op, 3'b010);
    repeat (3) idle_cyc(0);
    idle_cyc(1);
    run_ins(32'h002081B3, 2, 0, ab);
    lit("add_len", seq_len, 4);
    lit("add_wb", {snap[5].rw, snap[5].as, snap[5].op, snap[5].pw, snap[5].ps}, 8'b10_010_1_00);
    run_ins(32'h0000A183, 2, 0, ab);
    lit("lw_cnt", snap[1].cnt, 1);
    lit("lw_len", seq_len, 5);
    lit("lw_mem", snap[4].mr, 1);
    lit("lw_wb", {snap[5].rw, snap[5].m2r, snap[5].as}, 3'b111);
    run_ins(32'h0020A023, 2, 0, ab);
    lit("sw_mem", {snap[4].mw, snap[4].pw}, 2'b11);
    lit("sw_norw", snap[1].rw | snap[2].rw | snap[3].rw | snap[4].rw, 0);
    run_ins(32'h00208463, 1, 0, ab);
    lit("beq1_len", seq_len, 3);
    lit("beq1_ex", {snap[3].op, snap[3].pw, snap[3].ps}, 6'b110_1_01);
    run_ins(32'h00208463, 0, 0, ab);
    lit("beq0_ps", snap[3].ps, 0);
    run_ins(32'h0000007F, 2, 0, ab);
    lit("unk_len", seq_len, 2);
    lit("unk_dec", {snap[2].err, snap[2].pw, snap[2].ps}, 4'b1_1_00);
    run_ins(32'h40208133, 2, 0, ab);
    lit("sub_op", snap[3].op, 3'b110);
    lit("sub_err", snap[5].err, 1);
    lit("sub_cnt", snap[1].cnt, 6);
    while (!halted) run_ins(rnd_ins(), 2, 0, ab);
    repeat (4) halt_cyc();
    lit("halt_cnt", a.ins_count, MAXI);
    lit("halt_flags", {a.done, a.busy, a.pc_write}, 3'b100);
    do_reset();
    lit("rst2_cnt_err", {a.ins_count, a.err, a.done}, 0);
    idle_cyc(1);
    run_ins(32'h002081B3, 2, 0, ab);
    run_ins(32'h0000A183, 2, 3, ab);
    lit("lw_rst_abort", ab, 1);
    lit("lw_rst_state", {a.ins_count, a.busy, a.MemRead, a.RegWrite, a.ALUSrc, a.pc_write}, 0);
    idle_cyc(1);
    run_ins(32'h0000A183, 2, 0, ab);
    lit("lw_rerun", {snap[1].cnt, snap[4].mr}, 17'h1);
    for (int it = 0; it < 1200; it++) begin
      if (halted) begin
        repeat ($urandom_range(1, 3)) halt_cyc();
        do_reset();
        repeat ($urandom_range(0, 2)) idle_cyc(0);
        idle_cyc(1);
      end
      run_ins(rnd_ins(), 2, $urandom_range(0, 24) == 0 ? $urandom_range(1, 5) : 0, ab);
      if (ab) begin
        repeat ($urandom_range(0, 2)) idle_cyc(0);
        idle_cyc(1);
      end
    end
    chk = 0;
    @(negedge clk);
    b.start = 1; b.ins = 32'h00100093;
    @(negedge clk);
    b.start = 0;
    repeat (3) @(negedge clk);
    #2 lit("m2_wb1_pw", b.pc_write, 1);
    @(negedge clk);
    #2 lit("m2_f2", {b.ins_count, b.busy, b.done}, {16'd1, 2'b10});
    repeat (3) @(negedge clk);
    #2 lit("m2_wb2_pw", b.pc_write, 1);
    @(negedge clk);
    #2 lit("m2_halt", {b.ins_count, b.busy, b.done}, {16'd2, 2'b01});
    repeat (3) begin
      @(negedge clk);
      b.start = 1;
    end
    @(negedge clk);
    b.start = 0;
    #2 lit("m2_ignored", {b.ins_count, b.busy, b.done, b.err}, {16'd2, 3'b010});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
